// File: rtl/audio_adc_deserializer.sv
// I2S ADC receiver: synchronizes the codec bit stream, captures stereo words and buffers frames in a show-ahead FIFO.
// Define AUDIO_IN_DROP_COUNT_EN to add the saturating audio_in_drop_count output.
module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_ADCLRCK,
    input  logic                          AUD_ADCDAT,
    input  logic                          clear_audio_in_memory,
    input  logic                          read_audio_in,
    output logic                          audio_in_available,
    output logic [31:0]                   left_channel_audio_in,
    output logic [31:0]                   right_channel_audio_in,
    output logic                          audio_in_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   audio_in_level
`ifdef AUDIO_IN_DROP_COUNT_EN
    ,
    output logic [15:0]                   audio_in_drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int FW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {WAIT_FRAME, LEFT, RIGHT} state_t;

    logic [1:0] bclk_sync, lrck_sync, dat_sync;
    logic       bclk_prev;
    logic       bclk_rise, lrck, dat, lrck_held, lrck_rise, lrck_fall;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg, left_word, capture_word;
    logic [CW-1:0]         bit_cnt, shamt;

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [FW-1:0] head_frame, push_frame;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [LW-1:0] level;
    logic          push, full, empty, do_push, do_pop, drop, overflow;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], AUD_BCLK};
            lrck_sync <= {lrck_sync[0], AUD_ADCLRCK};
            dat_sync  <= {dat_sync[0], AUD_ADCDAT};
            bclk_prev <= bclk_sync[1];
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_prev;
    assign lrck      = lrck_sync[1];
    assign dat       = dat_sync[1];
    assign lrck_rise = bclk_rise & ~lrck_held & lrck;
    assign lrck_fall = bclk_rise & lrck_held & ~lrck;

    // Bits land MSB-first at a falling position so a short word stays left-aligned.
    assign shamt        = CW'(DATA_WIDTH - 1) - bit_cnt;
    assign capture_word = shift_reg | (DATA_WIDTH'(dat) << shamt);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= WAIT_FRAME;
            lrck_held <= 1'b0;
            shift_reg <= '0;
            left_word <= '0;
            bit_cnt   <= '0;
        end else if (bclk_rise) begin
            lrck_held <= lrck;
            case (state)
                WAIT_FRAME: begin
                    if (lrck_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= LEFT;
                    end
                end
                LEFT: begin
                    if (lrck_rise) begin
                        left_word <= shift_reg;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= RIGHT;
                    end else if (bit_cnt < CW'(DATA_WIDTH)) begin
                        shift_reg <= capture_word;
                        bit_cnt   <= bit_cnt + CW'(1);
                    end
                end
                RIGHT: begin
                    if (lrck_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= LEFT;
                    end else if (bit_cnt < CW'(DATA_WIDTH)) begin
                        shift_reg <= capture_word;
                        bit_cnt   <= bit_cnt + CW'(1);
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

    assign push       = lrck_fall && (state == RIGHT);
    assign push_frame = {left_word, shift_reg};

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = read_audio_in && !empty && !clear_audio_in_memory;
    assign do_push = push && !clear_audio_in_memory && (!full || do_pop);
    assign drop    = push && !clear_audio_in_memory && full && !do_pop;
    assign rd_next = rd_ptr + AW'(1);

    always_ff @(posedge CLOCK_50) begin
        if (do_push)
            mem[wr_ptr] <= push_frame;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_frame <= '0;
            overflow   <= 1'b0;
        end else if (clear_audio_in_memory) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_next;
            if (do_push && !do_pop)
                level <= level + LW'(1);
            else if (do_pop && !do_push)
                level <= level - LW'(1);
            if (drop)
                overflow <= 1'b1;
            // Head register keeps the last popped frame once the FIFO drains.
            if (do_pop) begin
                if (level > LW'(1))
                    head_frame <= mem[rd_next];
                else if (do_push)
                    head_frame <= push_frame;
            end else if (do_push && empty) begin
                head_frame <= push_frame;
            end
        end
    end

`ifdef AUDIO_IN_DROP_COUNT_EN
    logic [15:0] drop_count;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            drop_count <= '0;
        else if (clear_audio_in_memory)
            drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
    end

    assign audio_in_drop_count = drop_count;
`endif

    assign audio_in_available     = !empty;
    assign audio_in_level         = level;
    assign audio_in_overflow      = overflow;
    assign left_channel_audio_in  = 32'($signed(head_frame[FW-1:DATA_WIDTH]));
    assign right_channel_audio_in = 32'($signed(head_frame[DATA_WIDTH-1:0]));

endmodule
